bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Central arbiter and chip-select decoder for the shared bus of the bus-trial example. Grants bus ownership to one of NUM_MASTERS requesters via the busrq_n/busack_n handshake, using round-robin priority. While a grant is active, decodes the top address bits into per-slave active-low chip enables for the memory slaves. Watches the wired buswait_n line and flags stalls.

## Interface
- NUM_MASTERS, 4: number of requesters, 2..8.
- NUM_SLAVES, 4: number of slaves; power of two, ≥2. SEL_BITS = $clog2(NUM_SLAVES).
- ADDR_WIDTH, 16: bus address width.
- WAIT_TIMEOUT, 64: consecutive buswait_n-low cycles that raise bus_timeout; 0 disables it.
- clk  in  1  clock.
- reset_n  in  1  reset, synchronous, active-low.
- busrq_n  in  NUM_MASTERS  per-master bus request, active-low, level.
- busack_n  out  NUM_MASTERS  per-master grant, active-low, registered.
- addr  in  ADDR_WIDTH  shared bus address, driven by the owner.
- rd_n, wr_n  in  1 each  shared bus strobes, active-low.
- buswait_n  in  1  wired wait line; pulled up at top level, so released reads 1.
- ce_n  out  NUM_SLAVES  slave chip enables, active-low.
- owner  out  max(1,$clog2(NUM_MASTERS))  index of the current grantee; valid when bus_busy=1.
- bus_busy  out  1  high while any busack_n is low.
- bus_timeout  out  1  one-cycle pulse when the wait timeout expires.

## Operation
- FSM states: IDLE, GRANTED, TURNAROUND.
- IDLE
  - If any busrq_n is low, pick a winner by round-robin, then go to GRANTED.
  - Drive busack_n[winner]=0 and set owner=winner.
- Round-robin priority:
  - Search starts at (last_owner+1) mod NUM_MASTERS and wraps.
  - last_owner resets to NUM_MASTERS-1, so master 0 has highest priority after reset.
- GRANTED: the grant is held while busrq_n[owner]=0.
- Release from GRANTED
  - Condition: busrq_n[owner]=1 AND rd_n=1 AND wr_n=1 AND buswait_n=1.
  - Action: set all busack_n=1, last_owner=owner, go to TURNAROUND.
  - If the owner releases while a strobe or wait is active, the grant is held until all three conditions are true.
- TURNAROUND: all acks high for exactly one cycle. Arbitration runs here too:
  - Request pending: go directly to GRANTED with the new winner.
  - No request: go to IDLE.
- Requests are sampled as levels. A request withdrawn before it is granted is simply never granted. The arbiter never preempts.
- ce_n[i] = 0 combinationally only when all of these hold:
  - state == GRANTED;
  - (rd_n==0 or wr_n==0);
  - addr[ADDR_WIDTH-1 -: SEL_BITS] == i.
  - Otherwise ce_n[i] = 1. At most one ce_n is low at a time.
- Wait counter
  - Increments each cycle buswait_n=0 in GRANTED, saturating at WAIT_TIMEOUT.
  - Cleared when buswait_n=1 or the state is not GRANTED.
  - bus_timeout pulses for one cycle when the count reaches WAIT_TIMEOUT. It does not pulse again until the counter has cleared.
  - The grant is not affected.

## Timing
- Reset values
  - Outputs: busack_n all 1, ce_n all 1, owner 0, bus_busy 0, bus_timeout 0.
  - Internal: state IDLE, last_owner NUM_MASTERS-1, wait counter 0.
- Reset asserted mid-grant: all outputs take their reset values at the same edge.
- Grant latency: busrq_n low, sampled at edge k in IDLE, gives busack_n low after edge k.
- Release latency
  - Release conditions met at edge k: busack_n goes high after edge k.
  - The next grantee's busack_n goes low after edge k+1.
  - Minimum gap between grants is one full cycle with all acks high.
- ce_n follows addr/rd_n/wr_n combinationally (no added latency) while GRANTED.
- bus_busy and owner are registered along with busack_n.

## Test plan
- Single request: after reset, busrq_n=4'b1110 → busack_n=4'b1110 one cycle later, owner=0, bus_busy=1. Release busrq_n → acks 4'b1111 next cycle → IDLE.
- Round-robin:
  - Stimulus: all four requesting continuously, each master releasing after 3 cycles of ownership and re-requesting.
  - Required: grant order 0,1,2,3,0; exactly one all-high cycle between grants.
- Decode with wait-hold
  - Owner drives addr=16'h8001, wr_n=0 → ce_n=4'b1011. Memory slave 2 pulls buswait_n low for 2 cycles.
  - Owner releases busrq_n during the wait → grant is held until buswait_n=1 and wr_n=1.
- Timeout: WAIT_TIMEOUT=4, buswait_n held low 10 cycles in GRANTED → single bus_timeout pulse on the 4th cycle; grant is retained.
- Reset mid-grant: master 2 owns the bus with rd_n=0 → assert reset_n=0 → next edge busack_n=4'b1111, ce_n=4'b1111, owner=0. After release of reset, simultaneous requests from masters 2 and 3 → master 0 priority restored, so 2 wins.

Source files
------------

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with busrq_n/busack_n handshake, slave chip-select
// decode for the current grant, and a buswait_n stall watchdog.
module bus_arbiter #(
    parameter int unsigned NUM_MASTERS  = 4,
    parameter int unsigned NUM_SLAVES   = 4,
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned WAIT_TIMEOUT = 64,
    localparam int unsigned OWNER_W     = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_MASTERS-1:0] busrq_n,
    output logic [NUM_MASTERS-1:0] busack_n,
    input  logic [ADDR_WIDTH-1:0]  addr,
    input  logic                   rd_n,
    input  logic                   wr_n,
    input  logic                   buswait_n,
    output logic [NUM_SLAVES-1:0]  ce_n,
    output logic [OWNER_W-1:0]     owner,
    output logic                   bus_busy,
    output logic                   bus_timeout
);

    localparam int unsigned SEL_BITS = $clog2(NUM_SLAVES);
    localparam int unsigned CNT_W    = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANTED = 2'd1,
        ST_TURN    = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [NUM_MASTERS-1:0] busack_q, busack_d;
    logic [OWNER_W-1:0]     owner_q, owner_d;
    logic [OWNER_W-1:0]     last_q, last_d;
    logic                   busy_q, busy_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   timeout_q, timeout_d;

    logic                   any_req_c;
    logic                   release_c;
    logic [OWNER_W-1:0]     winner_c;

    // State and output registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            busack_q  <= '1;
            owner_q   <= '0;
            last_q    <= OWNER_W'(NUM_MASTERS - 1);
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            busack_q  <= busack_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Round-robin search starting just after the last owner
    always_comb begin
        int unsigned idx;
        logic        found;
        idx      = 0;
        found    = 1'b0;
        winner_c = last_q;
        for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
            idx = 32'(last_q) + k;
            if (idx >= NUM_MASTERS) begin
                idx = idx - NUM_MASTERS;
            end
            if (!found && !busrq_n[OWNER_W'(idx)]) begin
                found    = 1'b1;
                winner_c = OWNER_W'(idx);
            end
        end
    end

    assign any_req_c = ~&busrq_n;
    assign release_c = (state_q == ST_GRANTED) && busrq_n[owner_q] && rd_n && wr_n && buswait_n;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (any_req_c) state_d = ST_GRANTED;
            ST_GRANTED: if (release_c) state_d = ST_TURN;
            ST_TURN:    state_d = any_req_c ? ST_GRANTED : ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Registered-output and wait-counter next values
    always_comb begin
        busack_d  = busack_q;
        owner_d   = owner_q;
        last_d    = last_q;
        busy_d    = busy_q;
        cnt_d     = '0;
        timeout_d = 1'b0;

        if ((state_q == ST_IDLE) || (state_q == ST_TURN)) begin
            busack_d = '1;
            busy_d   = 1'b0;
            if (any_req_c) begin
                busack_d = ~(NUM_MASTERS'(1) << winner_c);
                owner_d  = winner_c;
                busy_d   = 1'b1;
            end
        end else if (release_c) begin
            busack_d = '1;
            busy_d   = 1'b0;
            last_d   = owner_q;
        end

        // Stall watchdog: saturates, so the pulse fires once per wait episode
        if ((state_q == ST_GRANTED) && !buswait_n) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end
        timeout_d = (WAIT_TIMEOUT != 0) && (cnt_d == CNT_MAX) && (cnt_q != CNT_MAX);
    end

    // Chip-select decode follows the bus combinationally during a grant
    always_comb begin
        ce_n = '1;
        if ((state_q == ST_GRANTED) && (!rd_n || !wr_n)) begin
            ce_n[addr[ADDR_WIDTH-1 -: SEL_BITS]] = 1'b0;
        end
    end

    assign busack_n    = busack_q;
    assign owner       = owner_q;
    assign bus_busy    = busy_q;
    assign bus_timeout = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized
// traffic compared against a transaction-level ownership model.
module tb_bus_arbiter;

    localparam int unsigned NM = 4;
    localparam int unsigned NS = 4;
    localparam int unsigned AW = 16;
    localparam int unsigned WT = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [NM-1:0] busrq_n;
    logic [NM-1:0] busack_n;
    logic [AW-1:0] addr;
    logic          rd_n;
    logic          wr_n;
    logic          buswait_n;
    logic [NS-1:0] ce_n;
    logic [1:0]    owner;
    logic          bus_busy;
    logic          bus_timeout;

    always #5 clk = ~clk;

    bus_arbiter #(
        .NUM_MASTERS (NM),
        .NUM_SLAVES  (NS),
        .ADDR_WIDTH  (AW),
        .WAIT_TIMEOUT(WT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .busrq_n    (busrq_n),
        .busack_n   (busack_n),
        .addr       (addr),
        .rd_n       (rd_n),
        .wr_n       (wr_n),
        .buswait_n  (buswait_n),
        .ce_n       (ce_n),
        .owner      (owner),
        .bus_busy   (bus_busy),
        .bus_timeout(bus_timeout)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who owns the bus, who owned it last, how long it has stalled
    bit m_busy;
    int m_owner;
    int m_last;
    int m_wait;
    bit m_to;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [NM-1:0] req_n, input int last);
        for (int k = 1; k <= int'(NM); k++) begin
            int c;
            c = (last + k) % int'(NM);
            if (!req_n[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_edge();
        int w;
        m_to = 0;
        if (!reset_n) begin
            m_busy  = 0;
            m_owner = 0;
            m_last  = NM - 1;
            m_wait  = 0;
            return;
        end
        if (m_busy) begin
            if (!buswait_n) begin
                m_wait++;
                if (WT != 0 && m_wait == int'(WT)) m_to = 1;
            end else begin
                m_wait = 0;
            end
            if (busrq_n[m_owner] && rd_n && wr_n && buswait_n) begin
                m_busy = 0;
                m_last = m_owner;
                m_wait = 0;
            end
        end else begin
            m_wait = 0;
            w = rr_pick(busrq_n, m_last);
            if (w >= 0) begin
                m_busy  = 1;
                m_owner = w;
            end
        end
    endtask

    function automatic logic [NS-1:0] exp_ce();
        logic [NS-1:0] v;
        logic [AW-1:0] a;
        v = '1;
        a = addr;
        if (m_busy && (!rd_n || !wr_n)) v[a[AW-1 -: 2]] = 1'b0;
        return v;
    endfunction

    task automatic check_ce(input string tag);
        check(tag, 32'(ce_n), 32'(exp_ce()));
    endtask

    task automatic tick();
        logic [NM-1:0] ea;
        @(posedge clk);
        model_edge();
        #1;
        ea = m_busy ? ~(NM'(1) << m_owner) : '1;
        check("ack", 32'(busack_n), 32'(ea));
        check("busy", 32'(bus_busy), 32'(m_busy));
        check("timeout", 32'(bus_timeout), 32'(m_to));
        if (m_busy) check("owner", 32'(owner), 32'(m_owner));
        check_ce("ce");
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        busrq_n   = '1;
        rd_n      = 1'b1;
        wr_n      = 1'b1;
        buswait_n = 1'b1;
        addr      = '0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        int rr_exp[5] = '{0, 1, 2, 3, 0};
        int grants[$];
        int gap;
        int own_cyc;
        int cyc;
        int pulses;
        int pulse_at;
        logic [NM-1:0] prev_ack;

        // Reset state
        do_reset();
        check("rst_ack", 32'(busack_n), 32'hF);
        check("rst_owner", 32'(owner), 32'h0);
        check("rst_busy", 32'(bus_busy), 32'h0);

        // Single request
        busrq_n = 4'b1110;
        tick();
        check("single_ack", 32'(busack_n), 32'hE);
        check("single_owner", 32'(owner), 32'h0);
        busrq_n = '1;
        tick();
        check("single_rel", 32'(busack_n), 32'hF);
        tick();

        // Round-robin with all masters requesting, 3-cycle tenures
        do_reset();
        busrq_n  = '0;
        gap      = 0;
        own_cyc  = 0;
        cyc      = 0;
        prev_ack = '1;
        while (grants.size() < 5 && cyc < 80) begin
            tick();
            cyc++;
            if (busack_n == '1) begin
                gap++;
            end else if (prev_ack == '1) begin
                grants.push_back(int'(owner));
                if (grants.size() > 1) check("rr_gap", 32'(gap), 32'd1);
                gap = 0;
            end
            prev_ack = busack_n;
            if (m_busy) begin
                own_cyc++;
                busrq_n = '0;
                if (own_cyc == 3) busrq_n[m_owner] = 1'b1;
            end else begin
                own_cyc = 0;
                busrq_n = '0;
            end
        end
        check("rr_count", 32'(grants.size()), 32'd5);
        foreach (grants[i]) if (i < 5) check("rr_order", 32'(grants[i]), 32'(rr_exp[i]));
        busrq_n = '1;
        repeat (3) tick();

        // Decode with wait-hold
        busrq_n = 4'b1101;
        tick();
        addr = 16'h8001;
        wr_n = 1'b0;
        #1;
        check("dec_ce", 32'(ce_n), 32'hB);
        buswait_n = 1'b0;
        busrq_n   = '1;
        tick();
        tick();
        check("hold_wait", 32'(busack_n), 32'hD);
        buswait_n = 1'b1;
        tick();
        check("hold_strobe", 32'(busack_n), 32'hD);
        wr_n = 1'b1;
        #1;
        check("dec_ce_off", 32'(ce_n), 32'hF);
        tick();
        check("hold_rel", 32'(busack_n), 32'hF);
        tick();

        // Stall timeout: one pulse on the 4th wait cycle, grant kept
        busrq_n = 4'b1011;
        tick();
        buswait_n = 1'b0;
        pulses    = 0;
        pulse_at  = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (bus_timeout) begin
                pulses++;
                pulse_at = i;
            end
        end
        check("to_pulses", 32'(pulses), 32'd1);
        check("to_cycle", 32'(pulse_at), 32'd4);
        check("to_grant", 32'(busack_n), 32'hB);
        buswait_n = 1'b1;
        busrq_n   = '1;
        repeat (2) tick();

        // Reset mid-grant, then priority restored to master 0
        busrq_n = 4'b1011;
        tick();
        rd_n = 1'b0;
        addr = 16'h4000;
        #1;
        reset_n = 1'b0;
        tick();
        check("mid_ack", 32'(busack_n), 32'hF);
        check("mid_ce", 32'(ce_n), 32'hF);
        check("mid_owner", 32'(owner), 32'h0);
        reset_n = 1'b1;
        rd_n    = 1'b1;
        busrq_n = 4'b0011;
        tick();
        check("mid_regrant", 32'(busack_n), 32'hB);
        check("mid_winner", 32'(owner), 32'h2);
        busrq_n = '1;
        repeat (2) tick();

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            for (int j = 0; j < int'(NM); j++) begin
                if ($urandom_range(0, 4) == 0) busrq_n[j] = ~busrq_n[j];
            end
            rd_n      = ($urandom_range(0, 3) != 0);
            wr_n      = ($urandom_range(0, 3) != 0);
            buswait_n = ($urandom_range(0, 9) > 3);
            if ($urandom_range(0, 40) == 0) buswait_n = 1'b0;
            addr      = AW'($urandom);
            reset_n   = ($urandom_range(0, 199) != 0);
            #1;
            check_ce("rnd_ce");
            tick();
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
